hack_mem_resp: RTL and testbench
================================

HACK_MEM_RESP -- requirements
Module: hack_mem_resp

Interface
REQ-001 SHALL have parameter RAM_AW, default 14, meaning data RAM address width (16384 words at 0x0000-0x3FFF).
REQ-002 SHALL have parameter KBD_CLR_ON_RD, default 1, meaning a CPU read of 0x6000 releases the keyboard register.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock, rising edge; rstn  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: addressMR  in  16  read address; addressMW  in  16  write address; writeM  in  1  write strobe; outM  in  16  write data; inM  out  16  read data.
REQ-005 SHALL have ports: kbd_valid  in  1  key offered; kbd_data  in  16  key code; kbd_ready  out  1  key register empty.
REQ-006 SHALL have ports: scr_valid  out  1  screen update pending; scr_addr  out  13  screen word offset; scr_data  out  16  screen word; scr_ready  in  1  display accepts; scr_ovf  out  1  sticky dropped-update flag.

Function
REQ-007 SHALL decode addresses as: 0x0000-0x3FFF RAM; 0x4000-0x5FFF screen shadow RAM (8192 words); 0x6000 keyboard; all others unmapped.
REQ-008 SHALL register inM: inM at edge N+1 = word at addressMR sampled at edge N; latency 1 cycle.
REQ-009 SHALL return 0 for reads of unmapped addresses; writes to unmapped addresses SHALL be ignored.
REQ-010 SHALL write outM to addressMW at a rising edge when writeM=1.
REQ-011 SHALL be read-first: addressMR==addressMW with writeM=1 returns the old word on inM.
REQ-012 SHALL drive kbd_ready=!kbd_full; kbd_valid&kbd_ready captures kbd_data and sets kbd_full.
REQ-013 SHALL return the key register on a 0x6000 read when kbd_full=1, else 0.
REQ-014 SHALL clear kbd_full on a CPU write to 0x6000 (any data), and also on a 0x6000 read when KBD_CLR_ON_RD=1; the clear takes effect at the same edge as the returned data.
REQ-015 SHALL give clear priority over capture when both occur at one edge; no capture occurs then because kbd_ready=0.
REQ-016 SHALL, on a screen-range write, update the shadow RAM and push {addressMW[12:0], outM} to the screen queue.
REQ-017 SHALL drive scr_valid=!queue_empty with scr_addr/scr_data from the head entry held stable until scr_valid&scr_ready.
REQ-018 SHALL, on a push when the queue is full and no pop occurs at that edge, drop the new entry and set scr_ovf.
REQ-019 SHALL, on a simultaneous push and pop when full, accept the push without setting scr_ovf.
REQ-020 SHALL keep scr_ovf set until reset.

Reset
REQ-021 SHALL asynchronously, on rstn=0, set inM=0, kbd_full=0 (kbd_ready=1), empty the screen queue (scr_valid=0, scr_addr=0, scr_data=0), and clear scr_ovf.
REQ-022 SHALL not clear RAM or shadow RAM on reset; a reset mid-transfer SHALL discard queued screen entries.

Configuration
REQ-023 SHALL, with HACK_SCREEN_FIFO_EN defined, implement the screen queue as a 4-entry FIFO.
REQ-024 SHALL, without HACK_SCREEN_FIFO_EN, implement the screen queue as a 1-entry holding register, with full/overflow rules per REQ-018/019 at depth 1.

Structure
REQ-025 SHALL place the address map constants (RAM_BASE, SCR_BASE, SCR_WORDS, KBD_ADDR) and the screen-entry struct {addr[12:0], data[15:0]} in the shared package hack_mem_pkg.
REQ-026 SHALL implement the screen queue as sub-module hack_sync_fifo (parameter DEPTH, 4 or 1).

Verification
REQ-027 SHALL check: write 0x1234 to 0x0010, then read 0x0010 -> inM=0x1234 exactly one cycle after the address.
REQ-028 SHALL check: kbd_valid=1, kbd_data=0x0041 -> kbd_ready falls; read 0x6000 -> inM=0x0041, kbd_ready=1 next cycle; a second read -> 0.
REQ-029 SHALL check: scr_ready=0 with five writes to 0x4000-0x4004 (FIFO build) -> four entries held, scr_ovf=1; raising scr_ready -> offsets 0,1,2,3 drained in order.
REQ-030 SHALL check: same-cycle write 0xBEEF to 0x0020 and read of 0x0020 holding 0x0001 -> inM=0x0001, next read 0xBEEF.
REQ-031 SHALL check: rstn asserted with two queued screen entries and kbd_full=1 -> scr_valid=0, kbd_ready=1, scr_ovf=0, inM=0 immediately, without a clock edge.
REQ-032 SHALL check: reads of 0x6001 and 0x7FFF -> inM=0; a write to 0x7000 leaves all state unchanged.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared address map, bus widths and screen-queue entry type for the Hack memory responder.
package hack_mem_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned SCR_AW    = 13;

    localparam logic [ADDR_W-1:0] RAM_BASE  = 16'h0000;
    localparam logic [ADDR_W-1:0] SCR_BASE  = 16'h4000;
    localparam int unsigned       SCR_WORDS = 8192;
    localparam logic [ADDR_W-1:0] KBD_ADDR  = 16'h6000;

    // One pending screen update: word offset within the screen window plus data
    typedef struct packed {
        logic [SCR_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } scr_entry_t;

    // True when addr falls in [base, base+words); the wrapped offset rejects addresses below base
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input int unsigned       words);
        logic [ADDR_W-1:0] off;
        off = addr - base;
        return (32'(off) < words);
    endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// Small synchronous FIFO for screen updates; accepts a push into a full queue only when a pop
// happens at the same edge. Storage is reset so the head reads as zero after reset.
module hack_sync_fifo
    import hack_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  scr_entry_t push_data,
    input  logic       pop,
    output scr_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    scr_entry_t        mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + PW'(1));
    endfunction

    // Handshake qualification, pointer and occupancy update
    always_comb begin
        pop_ok   = pop & (cnt_q != '0);
        push_ok  = push & ((cnt_q != CW'(DEPTH)) | pop_ok);
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = CW'(cnt_q + CW'(1));
            2'b01:   cnt_d = CW'(cnt_q - CW'(1));
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/hack_mem_resp.sv
// Hack data-memory responder: RAM, screen shadow RAM with an update queue to the display,
// and a one-word keyboard register. Define HACK_SCREEN_FIFO_EN for a 4-deep screen queue;
// otherwise a single holding register is used.
module hack_mem_resp
    import hack_mem_pkg::*;
#(
    parameter int unsigned RAM_AW        = 14,
    parameter bit          KBD_CLR_ON_RD = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] addressMR,
    input  logic [ADDR_W-1:0] addressMW,
    input  logic              writeM,
    input  logic [DATA_W-1:0] outM,
    output logic [DATA_W-1:0] inM,
    input  logic              kbd_valid,
    input  logic [DATA_W-1:0] kbd_data,
    output logic              kbd_ready,
    output logic              scr_valid,
    output logic [SCR_AW-1:0] scr_addr,
    output logic [DATA_W-1:0] scr_data,
    input  logic              scr_ready,
    output logic              scr_ovf
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;
`ifdef HACK_SCREEN_FIFO_EN
    localparam int unsigned SCR_DEPTH = 4;
`else
    localparam int unsigned SCR_DEPTH = 1;
`endif

    logic [DATA_W-1:0] ram_mem [RAM_WORDS];
    logic [DATA_W-1:0] scr_mem [SCR_WORDS];

    logic [DATA_W-1:0] inm_q, inm_d;
    logic              kbd_full_q, kbd_full_d;
    logic [DATA_W-1:0] kbd_data_q, kbd_data_d;
    logic              scr_ovf_q, scr_ovf_d;

    logic rd_ram, rd_scr, rd_kbd;
    logic wr_ram, wr_scr, wr_kbd;
    logic kbd_clr, kbd_cap;
    logic scr_push, scr_pop, fifo_empty, fifo_full;
    scr_entry_t push_entry, head_entry;

    // Address decode for both ports
    always_comb begin
        rd_ram = in_window(addressMR, RAM_BASE, RAM_WORDS);
        rd_scr = in_window(addressMR, SCR_BASE, SCR_WORDS);
        rd_kbd = (addressMR == KBD_ADDR);
        wr_ram = writeM & in_window(addressMW, RAM_BASE, RAM_WORDS);
        wr_scr = writeM & in_window(addressMW, SCR_BASE, SCR_WORDS);
        wr_kbd = writeM & (addressMW == KBD_ADDR);
    end

    // Read mux; memory arrays are read before this edge's write lands, giving read-first behaviour
    always_comb begin
        inm_d = '0;
        if (rd_ram) begin
            inm_d = ram_mem[addressMR[RAM_AW-1:0]];
        end else if (rd_scr) begin
            inm_d = scr_mem[addressMR[SCR_AW-1:0]];
        end else if (rd_kbd) begin
            inm_d = kbd_full_q ? kbd_data_q : '0;
        end
    end

    // Keyboard register: a release only applies to a held key, so it never races a capture
    always_comb begin
        kbd_clr    = kbd_full_q & (wr_kbd | (KBD_CLR_ON_RD & rd_kbd));
        kbd_cap    = kbd_valid & ~kbd_full_q;
        kbd_full_d = kbd_full_q;
        kbd_data_d = kbd_data_q;
        if (kbd_clr) begin
            kbd_full_d = 1'b0;
        end else if (kbd_cap) begin
            kbd_full_d = 1'b1;
            kbd_data_d = kbd_data;
        end
    end

    // Screen queue control and sticky drop flag
    always_comb begin
        scr_push        = wr_scr;
        scr_pop         = ~fifo_empty & scr_ready;
        push_entry.addr = addressMW[SCR_AW-1:0];
        push_entry.data = outM;
        scr_ovf_d       = scr_ovf_q | (scr_push & fifo_full & ~scr_pop);
    end

    // Control registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inm_q      <= '0;
            kbd_full_q <= 1'b0;
            kbd_data_q <= '0;
            scr_ovf_q  <= 1'b0;
        end else begin
            inm_q      <= inm_d;
            kbd_full_q <= kbd_full_d;
            kbd_data_q <= kbd_data_d;
            scr_ovf_q  <= scr_ovf_d;
        end
    end

    // Data RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_ram) ram_mem[addressMW[RAM_AW-1:0]] <= outM;
    end

    // Screen shadow RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_scr) scr_mem[addressMW[SCR_AW-1:0]] <= outM;
    end

    hack_sync_fifo #(
        .DEPTH (SCR_DEPTH)
    ) u_scr_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (scr_push),
        .push_data (push_entry),
        .pop       (scr_pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign inM       = inm_q;
    assign kbd_ready = ~kbd_full_q;
    assign scr_valid = ~fifo_empty;
    assign scr_addr  = head_entry.addr;
    assign scr_data  = head_entry.data;
    assign scr_ovf   = scr_ovf_q;

endmodule

// File: tb/tb_hack_mem_resp.sv
// Directed scoreboard bench for hack_mem_resp (default parameters).
module tb_hack_mem_resp;

`ifdef HACK_SCREEN_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] addressMR, addressMW, outM, inM, kbd_data, scr_data;
    logic        writeM, kbd_valid, kbd_ready, scr_valid, scr_ready, scr_ovf;
    logic [12:0] scr_addr;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [int];
    logic [16:0] rd_q  [$];
    logic [28:0] scr_q [$];
    logic        kbd_full_m, ovf_m;
    logic [15:0] kbd_data_m;

    hack_mem_resp dut (
        .clk       (clk),
        .rstn      (rstn),
        .addressMR (addressMR),
        .addressMW (addressMW),
        .writeM    (writeM),
        .outM      (outM),
        .inM       (inM),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .scr_valid (scr_valid),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .scr_ready (scr_ready),
        .scr_ovf   (scr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive ports, check pre-edge state, update the model, check registered results
    task automatic cyc(input logic [15:0] ra, input logic [15:0] wa,
                       input logic we, input logic [15:0] wd);
        logic [16:0] r;
        logic        pop, push, full, clr, cap;
        addressMR = ra;
        addressMW = wa;
        writeM    = we;
        outM      = wd;
        chk("kbd_ready", 32'(kbd_ready), 32'(!kbd_full_m));
        chk("scr_valid", 32'(scr_valid), 32'(scr_q.size() != 0));
        if (scr_q.size() != 0) chk("scr_head", 32'({scr_addr, scr_data}), 32'(scr_q[0]));
        if (ra < 16'h6000)
            r = mem_m.exists(int'(ra)) ? {1'b1, mem_m[int'(ra)]} : 17'h0;
        else if (ra == 16'h6000)
            r = {1'b1, (kbd_full_m ? kbd_data_m : 16'h0000)};
        else
            r = {1'b1, 16'h0000};
        rd_q.push_back(r);
        clr = kbd_full_m && ((we && wa == 16'h6000) || ra == 16'h6000);
        cap = kbd_valid && !kbd_full_m;
        if (clr) kbd_full_m = 1'b0;
        else if (cap) begin
            kbd_full_m = 1'b1;
            kbd_data_m = kbd_data;
        end
        pop  = (scr_q.size() != 0) && scr_ready;
        push = we && wa >= 16'h4000 && wa < 16'h6000;
        full = (scr_q.size() == DEPTH);
        if (push && full && !pop) ovf_m = 1'b1;
        if (pop) void'(scr_q.pop_front());
        if (push && (!full || pop)) scr_q.push_back({wa[12:0], wd});
        if (we && wa < 16'h6000) mem_m[int'(wa)] = wd;
        @(posedge clk);
        #1;
        r = rd_q.pop_front();
        if (r[16]) chk("inM", 32'(inM), 32'(r[15:0]));
        chk("scr_ovf", 32'(scr_ovf), 32'(ovf_m));
    endtask

    task automatic idle();
        cyc(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000);
    endtask

    initial begin
        addressMR = 16'h7FFF; addressMW = 16'h7FFF; writeM = 1'b0; outM = '0;
        kbd_valid = 1'b0; kbd_data = '0; scr_ready = 1'b1;
        kbd_full_m = 1'b0; ovf_m = 1'b0; kbd_data_m = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("rst_inM", 32'(inM), 32'h0);
        chk("rst_kbd_ready", 32'(kbd_ready), 32'h1);
        chk("rst_scr_valid", 32'(scr_valid), 32'h0);
        chk("rst_scr_addr", 32'(scr_addr), 32'h0);
        chk("rst_scr_data", 32'(scr_data), 32'h0);
        chk("rst_scr_ovf", 32'(scr_ovf), 32'h0);
        #10 rstn = 1'b1;
        @(posedge clk);
        #1;

        // RAM write then read, one-cycle latency
        cyc(16'h7FFF, 16'h0010, 1'b1, 16'h1234);
        cyc(16'h0010, 16'h7FFF, 1'b0, 16'h0000);
        idle();

        // Read-first on same-address read and write
        cyc(16'h7FFF, 16'h0020, 1'b1, 16'h0001);
        cyc(16'h0020, 16'h0020, 1'b1, 16'hBEEF);
        cyc(16'h0020, 16'h7FFF, 1'b0, 16'h0000);

        // Keyboard capture and release on read
        kbd_valid = 1'b1; kbd_data = 16'h0041;
        idle();
        kbd_valid = 1'b0;
        cyc(16'h6000, 16'h7FFF, 1'b0, 16'h0000);
        cyc(16'h6000, 16'h7FFF, 1'b0, 16'h0000);

        // Keyboard release on write
        kbd_valid = 1'b1; kbd_data = 16'h0042;
        idle();
        kbd_valid = 1'b0;
        cyc(16'h7FFF, 16'h6000, 1'b1, 16'hFFFF);
        cyc(16'h6000, 16'h7FFF, 1'b0, 16'h0000);

        // Unmapped reads and an ignored unmapped write
        cyc(16'h7FFF, 16'h3000, 1'b1, 16'hAAAA);
        cyc(16'h7FFF, 16'h5000, 1'b1, 16'h5555);
        cyc(16'h6001, 16'h7000, 1'b1, 16'hDEAD);
        cyc(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000);
        cyc(16'h3000, 16'h7FFF, 1'b0, 16'h0000);
        cyc(16'h5000, 16'h7FFF, 1'b0, 16'h0000);
        cyc(16'h0010, 16'h7FFF, 1'b0, 16'h0000);
        cyc(16'h0020, 16'h7FFF, 1'b0, 16'h0000);
        cyc(16'hFFFF, 16'h7FFF, 1'b0, 16'h0000);

        // Fill screen queue past capacity, then drain in order
        scr_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc(16'h7FFF, 16'(16'h4000 + i), 1'b1, 16'(16'hC000 + i));
        chk("scr_ovf_set", 32'(scr_ovf), 32'h1);
        cyc(16'h4003, 16'h7FFF, 1'b0, 16'h0000);
        scr_ready = 1'b1;
        repeat (DEPTH + 2) idle();
        chk("scr_drained", 32'(scr_valid), 32'h0);

        // Asynchronous reset with queued entries and a held key
        scr_ready = 1'b0;
        cyc(16'h7FFF, 16'h4100, 1'b1, 16'h1111);
        cyc(16'h7FFF, 16'h4101, 1'b1, 16'h2222);
        kbd_valid = 1'b1; kbd_data = 16'h0055;
        idle();
        kbd_valid = 1'b0;
        cyc(16'h0010, 16'h7FFF, 1'b0, 16'h0000);
        #2 rstn = 1'b0;
        #1;
        chk("arst_scr_valid", 32'(scr_valid), 32'h0);
        chk("arst_kbd_ready", 32'(kbd_ready), 32'h1);
        chk("arst_scr_ovf", 32'(scr_ovf), 32'h0);
        chk("arst_inM", 32'(inM), 32'h0);
        chk("arst_scr_addr", 32'(scr_addr), 32'h0);
        scr_q.delete();
        kbd_full_m = 1'b0;
        ovf_m = 1'b0;
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        cyc(16'h0010, 16'h7FFF, 1'b0, 16'h0000);
        cyc(16'h4101, 16'h7FFF, 1'b0, 16'h0000);

        // Push and pop together on a full queue: accepted without overflow
        for (int i = 0; i < DEPTH; i++) cyc(16'h7FFF, 16'(16'h4200 + i), 1'b1, 16'(16'h7700 + i));
        scr_ready = 1'b1;
        cyc(16'h7FFF, 16'h4300, 1'b1, 16'h9999);
        repeat (DEPTH + 2) idle();
        chk("full_pushpop_ovf", 32'(scr_ovf), 32'h0);
        chk("full_pushpop_drained", 32'(scr_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
